// File: rtl/adc_bitslip_align_if.sv
// adc_bitslip_align_if: deserializer-side bus of the bitslip aligner.
// mismatch_cnt exists only when ALIGN_STATS_EN is defined.
interface adc_bitslip_align_if;
    logic       start;
    logic [5:0] qodd;
    logic [5:0] qevn;
    logic       bit_slip_odd;
    logic       bit_slip_evn;
    logic       busy;
    logic       locked;
    logic       align_err;
    logic [2:0] slip_cnt_odd;
    logic [2:0] slip_cnt_evn;
`ifdef ALIGN_STATS_EN
    logic [7:0] mismatch_cnt;
`endif
    modport master (
        output start, qodd, qevn,
`ifdef ALIGN_STATS_EN
        input mismatch_cnt,
`endif
        input bit_slip_odd, bit_slip_evn, busy, locked, align_err, slip_cnt_odd, slip_cnt_evn
    );
    modport slave (
        input start, qodd, qevn,
`ifdef ALIGN_STATS_EN
        output mismatch_cnt,
`endif
        output bit_slip_odd, bit_slip_evn, busy, locked, align_err, slip_cnt_odd, slip_cnt_evn
    );
endinterface

// File: rtl/adc_bitslip_align.sv
// adc_bitslip_align: two-lane ISERDES bitslip training FSM, odd lane first, then even.
// Define ALIGN_STATS_EN to add the saturating mismatch_cnt statistic.
module adc_bitslip_align #(
    parameter logic [11:0] PATTERN   = 12'h0FC,
    parameter int          WAIT_CYC  = 3,
    parameter int          MATCH_CNT = 4
) (
    input logic frame_clk,
    input logic rst_b,
    adc_bitslip_align_if.slave bus
);
    localparam logic [5:0] PAT_ODD = {PATTERN[11], PATTERN[9], PATTERN[7], PATTERN[5], PATTERN[3], PATTERN[1]};
    localparam logic [5:0] PAT_EVN = {PATTERN[10], PATTERN[8], PATTERN[6], PATTERN[4], PATTERN[2], PATTERN[0]};
    localparam logic [3:0] MC = 4'(MATCH_CNT - 1);
    localparam logic [3:0] WC = 4'(WAIT_CYC - 1);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CHK_ODD  = 4'd1;
    localparam logic [3:0] S_SLIP_ODD = 4'd2;
    localparam logic [3:0] S_WAIT_ODD = 4'd3;
    localparam logic [3:0] S_CHK_EVN  = 4'd4;
    localparam logic [3:0] S_SLIP_EVN = 4'd5;
    localparam logic [3:0] S_WAIT_EVN = 4'd6;
    localparam logic [3:0] S_LOCKED   = 4'd7;
    localparam logic [3:0] S_FAIL     = 4'd8;
    logic [3:0] state, nxt, mcnt, wcnt;
    logic chk, hit, go;
    always_comb begin
        chk = state == S_CHK_ODD || state == S_CHK_EVN;
        hit = state == S_CHK_ODD ? bus.qodd == PAT_ODD : bus.qevn == PAT_EVN;
        go  = bus.start && (state == S_IDLE || state == S_LOCKED || state == S_FAIL);
        nxt = state;
        case (state)
            S_IDLE, S_LOCKED, S_FAIL: nxt = go ? S_CHK_ODD : state;
            S_CHK_ODD:  nxt = hit ? (mcnt == MC ? S_CHK_EVN : state) : bus.slip_cnt_odd < 3'd5 ? S_SLIP_ODD : S_FAIL;
            S_SLIP_ODD: nxt = S_WAIT_ODD;
            S_WAIT_ODD: nxt = wcnt == WC ? S_CHK_ODD : state;
            S_CHK_EVN:  nxt = hit ? (mcnt == MC ? S_LOCKED : state) : bus.slip_cnt_evn < 3'd5 ? S_SLIP_EVN : S_FAIL;
            S_SLIP_EVN: nxt = S_WAIT_EVN;
            S_WAIT_EVN: nxt = wcnt == WC ? S_CHK_EVN : state;
            default:    nxt = S_IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge frame_clk or negedge rst_b) begin
        if (!rst_b) begin
            state            <= S_IDLE;
            mcnt             <= '0;
            wcnt             <= '0;
            bus.bit_slip_odd <= 1'b0;
            bus.bit_slip_evn <= 1'b0;
            bus.busy         <= 1'b0;
            bus.locked       <= 1'b0;
            bus.align_err    <= 1'b0;
            bus.slip_cnt_odd <= '0;
            bus.slip_cnt_evn <= '0;
`ifdef ALIGN_STATS_EN
            bus.mismatch_cnt <= '0;
`endif
        end else begin
            state            <= nxt;
            mcnt             <= chk && hit && mcnt != MC ? mcnt + 4'd1 : 4'd0;
            wcnt             <= nxt == state && (state == S_WAIT_ODD || state == S_WAIT_EVN) ? wcnt + 4'd1 : 4'd0;
            bus.bit_slip_odd <= nxt == S_SLIP_ODD;
            bus.bit_slip_evn <= nxt == S_SLIP_EVN;
            bus.busy         <= !(nxt == S_IDLE || nxt == S_LOCKED || nxt == S_FAIL);
            bus.locked       <= nxt == S_LOCKED;
            bus.align_err    <= nxt == S_FAIL;
            bus.slip_cnt_odd <= go ? 3'd0 : bus.slip_cnt_odd + 3'(nxt == S_SLIP_ODD);
            bus.slip_cnt_evn <= go ? 3'd0 : bus.slip_cnt_evn + 3'(nxt == S_SLIP_EVN);
`ifdef ALIGN_STATS_EN
            bus.mismatch_cnt <= go ? 8'd0 : bus.mismatch_cnt + 8'(chk && !hit && bus.mismatch_cnt != 8'hFF);
`endif
        end
    end
endmodule

// File: tb/tb_adc_bitslip_align.sv
// tb_adc_bitslip_align: randomized lane rotations against a slip-count/latency model, scoreboard-checked.
`timescale 1ns/1ps
module tb_adc_bitslip_align;
    localparam int W = 3;
    localparam int M = 4;
    localparam logic [5:0] P = 6'b001110;
    typedef struct {logic lk; logic er; int co; int ce; int lat; int mm; int t0;} exp_t;
    logic clk = 0;
    logic rst_b = 0;
    adc_bitslip_align_if bus();
    adc_bitslip_align dut (.frame_clk(clk), .rst_b(rst_b), .bus(bus.slave));
    always #5 clk = ~clk;
    exp_t sb[$];
    int checks = 0, fails = 0, cyc = 0, done_cnt = 0, tot_pulses = 0;
    int n_odd = 0, n_evn = 0, off_odd = 0, off_evn = 0;
    logic oz = 0, ez = 0;
    logic [1:0] po_d = 0, pe_d = 0;

    function automatic logic [5:0] rotl(logic [5:0] v, int r);
        for (int i = 0; i < r; i++) v = {v[4:0], v[5]};
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    // Deserializer model: each slip pulse left-rotates its lane, visible two cycles later.
    always @(negedge clk) begin
        if (po_d[1]) n_odd <= n_odd + 1;
        if (pe_d[1]) n_evn <= n_evn + 1;
        po_d <= {po_d[0], bus.bit_slip_odd};
        pe_d <= {pe_d[0], bus.bit_slip_evn};
    end
    always_comb begin
        bus.qodd = oz ? 6'd0 : rotl(P, (off_odd + n_odd) % 6);
        bus.qevn = ez ? 6'd0 : rotl(P, (off_evn + n_evn) % 6);
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        logic [7:0] m = 0;
`ifdef ALIGN_STATS_EN
        m = bus.mismatch_cnt;
`endif
        return int'({m, bus.bit_slip_odd, bus.bit_slip_evn, bus.busy, bus.locked, bus.align_err, bus.slip_cnt_odd, bus.slip_cnt_evn});
    endfunction

    // Each slip costs a mismatching frame, the slip cycle and the settle window; failing costs 5 slips plus a last mismatch.
    function automatic exp_t model(int ko, int ke, logic o0, logic e0);
        exp_t e;
        int fail_ph = 5 * (2 + W) + 1;
        e.t0 = 0;
        if (o0) begin
            e.lk = 0; e.er = 1; e.co = 5; e.ce = 0; e.lat = 1 + fail_ph; e.mm = 6;
        end else if (e0) begin
            e.lk = 0; e.er = 1; e.co = ko; e.ce = 5; e.lat = 1 + ko * (2 + W) + M + fail_ph; e.mm = ko + 6;
        end else begin
            e.lk = 1; e.er = 0; e.co = ko; e.ce = ke; e.lat = 1 + (ko + ke) * (2 + W) + 2 * M; e.mm = ko + ke;
        end
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        logic prev = 0;
        int po = 0, pe = 0, last_odd = -1, first_evn = -1, last_p = -100, viol = 0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                po = 0; pe = 0; last_odd = -1; first_evn = -1; last_p = -100; viol = 0;
            end
            if (bus.bit_slip_odd && bus.bit_slip_evn) viol++;
            if (bus.bit_slip_odd || bus.bit_slip_evn) begin
                tot_pulses++;
                if (!bus.busy || cyc - last_p < W + 1) viol++;
                last_p = cyc;
            end
            if (bus.bit_slip_odd) begin po++; last_odd = cyc; end
            if (bus.bit_slip_evn) begin pe++; if (first_evn < 0) first_evn = cyc; end
            if ((bus.locked || bus.align_err) && !prev) begin
                if (sb.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_done: locked=%0d align_err=%0d with nothing expected", bus.locked, bus.align_err);
                end else begin
                    e = sb.pop_front();
                    chk("locked", int'(bus.locked), int'(e.lk));
                    chk("align_err", int'(bus.align_err), int'(e.er));
                    chk("slip_cnt_odd", int'(bus.slip_cnt_odd), e.co);
                    chk("slip_cnt_evn", int'(bus.slip_cnt_evn), e.ce);
                    chk("latency", cyc - e.t0, e.lat);
                    chk("odd_pulses", po, e.co);
                    chk("evn_pulses", pe, e.ce);
                    chk("evn_before_odd", int'(first_evn >= 0 && first_evn < last_odd), 0);
                    chk("pulse_rules", viol, 0);
                    chk("busy_done", int'(bus.busy), 0);
`ifdef ALIGN_STATS_EN
                    chk("mismatch_cnt", int'(bus.mismatch_cnt), e.mm);
`endif
                end
                po = 0; pe = 0; last_odd = -1; first_evn = -1; viol = 0;
                done_cnt++;
            end
            prev = bus.locked || bus.align_err;
        end
    endtask

    task automatic run(int ko, int ke, logic o0, logic e0);
        exp_t e;
        int w = 0;
        int d0;
        oz = o0;
        ez = e0;
        off_odd = (12 - ko - n_odd % 6) % 6;
        off_evn = (12 - ke - n_evn % 6) % 6;
        repeat (2) @(negedge clk);
        e = model(ko, ke, o0, e0);
        e.t0 = cyc;
        sb.push_back(e);
        d0 = done_cnt;
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        chk("start_clears", int'({bus.busy, bus.locked, bus.align_err}), 4);
        while (done_cnt == d0 && w < 300) begin
            @(negedge clk);
            bus.start = 0;
            if (bus.busy && $urandom_range(0, 7) == 0) bus.start = 1;
            w++;
        end
        bus.start = 0;
        if (done_cnt == d0) begin
            checks++; fails++;
            $display("FAIL timeout: no lock/error after %0d cycles, expected within %0d", w, e.lat);
            sb.delete();
        end
    endtask

    initial begin
        int w, p0, r;
        bus.start = 0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        rst_b = 1;
        repeat (2) @(negedge clk);
        chk("idle_after_release", outs(), 0);
        run(0, 0, 0, 0);
        run(2, 0, 0, 0);
        run(1, 4, 0, 0);
        run(0, 0, 0, 1);
        run(0, 0, 0, 0);
        run(3, 2, 1, 0);
        // Abort mid-settle: reset lands in the first wait cycle after an odd slip.
        oz = 0; ez = 0;
        off_odd = (12 - 3 - n_odd % 6) % 6;
        off_evn = (12 - n_evn % 6) % 6;
        repeat (2) @(negedge clk);
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        w = 0;
        while (!bus.bit_slip_odd && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("slip_seen", int'(bus.bit_slip_odd), 1);
        @(negedge clk);
        #2 rst_b = 0;
        #1 chk("async_reset", outs(), 0);
        @(negedge clk);
        rst_b = 1;
        p0 = tot_pulses;
        repeat (20) @(negedge clk);
        chk("no_slip_after_reset", tot_pulses - p0, 0);
        chk("idle_after_reset", outs(), 0);
        run(3, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            r = $urandom_range(0, 9);
            run($urandom_range(0, 5), $urandom_range(0, 5), r == 0, r == 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule

// File: doc/adc_bitslip_align.md
ADC_BITSLIP_ALIGN -- requirements
Module: adc_bitslip_align

Interface
REQ-001 Parameter PATTERN, default 12'h0FC: expected ADC training word, odd lane {b11,b9,b7,b5,b3,b1}, even lane {b10,b8,b6,b4,b2,b0}.
REQ-002 Parameter WAIT_CYC, default 3: settle cycles after each slip pulse, legal range 1-15.
REQ-003 Parameter MATCH_CNT, default 4: consecutive matching frames required per lane, legal range 1-15.
REQ-004 FRAME_CLK  in  1  sole clock, frame-rate clock; the deserializer uses the same clock as CLKDIV.
REQ-005 RST_B  in  1  asynchronous active-low reset.
REQ-006 START  in  1  single-cycle request to begin alignment.
REQ-007 QODD  in  6  odd-lane word from the deserializer.
REQ-008 QEVN  in  6  even-lane word from the deserializer.
REQ-009 BIT_SLIP_ODD  out  1  one-cycle slip pulse to the odd ISERDES.
REQ-010 BIT_SLIP_EVN  out  1  one-cycle slip pulse to the even ISERDES.
REQ-011 BUSY  out  1  alignment in progress.
REQ-012 LOCKED  out  1  both lanes aligned.
REQ-013 ALIGN_ERR  out  1  alignment failed.
REQ-014 SLIP_CNT_ODD  out  3  slips issued to the odd lane.
REQ-015 SLIP_CNT_EVN  out  3  slips issued to the even lane.

Function
REQ-016 The block SHALL implement the FSM IDLE, CHK_ODD, SLIP_ODD, WAIT_ODD, CHK_EVN, SLIP_EVN, WAIT_EVN, LOCKED, FAIL, with all outputs registered.
REQ-017 IDLE/LOCKED/FAIL + START SHALL go to CHK_ODD next cycle, clearing slip counts, match counter, LOCKED and ALIGN_ERR; START in any other state SHALL be ignored.
REQ-018 CHK_x: QODD (or QEVN) equal to the PATTERN lane SHALL increment the match counter; on reaching MATCH_CNT, CHK_ODD SHALL go to CHK_EVN and CHK_EVN SHALL go to LOCKED.
REQ-019 CHK_x mismatch SHALL clear the match counter and go to SLIP_x if SLIP_CNT_x<5, else to FAIL.
REQ-020 SLIP_x SHALL last exactly one cycle, assert BIT_SLIP_x high for that cycle only, and increment SLIP_CNT_x.
REQ-021 WAIT_x SHALL hold for WAIT_CYC cycles, ignoring lane data, then return to CHK_x.
REQ-022 BIT_SLIP_ODD and BIT_SLIP_EVN SHALL never be asserted simultaneously, nor outside SLIP states.
REQ-023 BUSY SHALL be high in every state except IDLE, LOCKED and FAIL.
REQ-024 LOCKED SHALL be high only in LOCKED; ALIGN_ERR SHALL be high only in FAIL.
REQ-025 Slip counts SHALL hold their final values in LOCKED and FAIL, and SHALL not wrap (maximum 5, since 6 slips revisit rotation 0).
REQ-026 Latency: with lanes already aligned and no slips, LOCKED SHALL rise 2*MATCH_CNT+1 cycles after the START cycle.
REQ-027 LOCKED SHALL not monitor data; relock requires a new START.

Reset
REQ-028 RST_B low SHALL asynchronously force IDLE; all outputs and counters SHALL be 0.
REQ-029 Reset mid-alignment SHALL abort immediately with no further slip pulses; release SHALL leave the block in IDLE until START.

Configuration
REQ-030 With ALIGN_STATS_EN defined, the block SHALL add output MISMATCH_CNT[7:0]: a saturating (at 255) count of CHK-state mismatch frames, cleared on START and on reset.
REQ-031 Without ALIGN_STATS_EN, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Aligned lanes (QODD=QEVN=6'b001110), START -> no slips; LOCKED high 9 cycles after START (defaults); counts 0/0.
REQ-033 Odd lane rotated 2 bits (rotation model: one left-rotate per slip pulse, visible 2 cycles later), even aligned, START -> exactly 2 BIT_SLIP_ODD pulses, each followed by at least 3 quiet cycles; LOCKED; SLIP_CNT_ODD=2, SLIP_CNT_EVN=0.
REQ-034 Odd rotated 1, even rotated 4, START -> SLIP_CNT_ODD=1, SLIP_CNT_EVN=4; all even slips occur after the last odd slip; LOCKED.
REQ-035 QEVN held at 6'b000000, START -> 5 even slips, then ALIGN_ERR=1, LOCKED=0, BUSY=0; a second START clears ALIGN_ERR.
REQ-036 RST_B low during WAIT_ODD -> outputs immediately 0; after release there are no slip pulses until START; START with ALIGN_STATS_EN defined and 3 mismatches -> MISMATCH_CNT=3.
